// File: rtl/bist_ora_misr.sv
// Output response analyser for the full-adder BIST: MISR compaction of CUT
// responses, then a golden signature/count comparison reported as pass/fail.
module bist_ora_misr #(
  parameter int              RESP_W    = 2,
  parameter int              SIG_W     = 4,
  parameter logic [SIG_W-1:0] POLY     = 4'b0011,
  parameter logic [SIG_W-1:0] SEED     = 4'b0000,
  parameter logic [SIG_W-1:0] GOLDEN   = 4'b0000,
  parameter int              CNT_W     = 4,
  parameter int              EXP_COUNT = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_in,
  input  logic              tpg_complete,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  resp_count,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [SIG_W-1:0] resp_ext;
  logic [SIG_W-1:0] sig_step;

  // Feedback is applied when the MSB shifts out; the response folds in last.
  always_comb begin
    resp_ext               = '0;
    resp_ext[RESP_W-1:0]   = resp_in;
    sig_step = {sig_q[SIG_W-2:0], 1'b0}
             ^ ({SIG_W{sig_q[SIG_W-1]}} & POLY)
             ^ resp_ext;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    // start overrides everything, including a coincident tpg_complete.
    if (start) begin
      state_d = COMPACT;
      sig_d   = SEED;
      cnt_d   = '0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        COMPACT: begin
          if (resp_valid) begin
            sig_d = sig_step;
            if (cnt_q != {CNT_W{1'b1}})
              cnt_d = cnt_q + 1'b1;
          end
          if (tpg_complete)
            state_d = COMPARE;
        end
        COMPARE: begin
          state_d = DONE;
          pass_d  = (sig_q == GOLDEN) && (cnt_q == CNT_W'(EXP_COUNT));
          fail_d  = !((sig_q == GOLDEN) && (cnt_q == CNT_W'(EXP_COUNT)));
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    signature  = sig_q;
    resp_count = cnt_q;
    busy       = (state_q == COMPACT) || (state_q == COMPARE);
    done       = (state_q == DONE);
    pass       = done && pass_q;
    fail       = done && fail_q;
  end

endmodule

// File: tb/tb_bist_ora_misr.sv
// Directed bench for bist_ora_misr: vector table for the main flows plus
// hand sequences for async reset, idle behaviour and count saturation.
module tb_bist_ora_misr;

  logic       clock;
  logic       reset;
  logic       start;
  logic       resp_valid;
  logic [1:0] resp_in;
  logic       tpg_complete;
  logic [3:0] signature;
  logic [3:0] resp_count;
  logic       busy, done, pass, fail;

  int checks   = 0;
  int failures = 0;

  bist_ora_misr #(
    .RESP_W(2), .SIG_W(4), .POLY(4'b0011), .SEED(4'b0000),
    .GOLDEN(4'b0111), .CNT_W(4), .EXP_COUNT(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .resp_valid(resp_valid),
    .resp_in(resp_in), .tpg_complete(tpg_complete), .signature(signature),
    .resp_count(resp_count), .busy(busy), .done(done), .pass(pass), .fail(fail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       start;
    logic       vld;
    logic [1:0] rin;
    logic       tpg;
    logic [3:0] sig;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl [NV];

  function automatic vec_t mk(logic s, logic v, logic [1:0] r, logic t,
                              logic [3:0] sg, logic [3:0] c,
                              logic b, logic d, logic p, logic f);
    vec_t x;
    x.start = s; x.vld = v; x.rin = r; x.tpg = t;
    x.sig = sg; x.cnt = c; x.busy = b; x.done = d; x.pass = p; x.fail = f;
    return x;
  endfunction

  task automatic check(string name, logic [3:0] esig, logic [3:0] ecnt,
                       logic eb, logic ed, logic ep, logic ef);
    checks++;
    if ({signature, resp_count, busy, done, pass, fail} !==
        {esig, ecnt, eb, ed, ep, ef}) begin
      failures++;
      $display("FAIL %s: got sig=%b cnt=%0d busy=%b done=%b pass=%b fail=%b, want sig=%b cnt=%0d busy=%b done=%b pass=%b fail=%b",
               name, signature, resp_count, busy, done, pass, fail,
               esig, ecnt, eb, ed, ep, ef);
    end else begin
      $display("ok   %s: sig=%b cnt=%0d busy=%b done=%b pass=%b fail=%b",
               name, signature, resp_count, busy, done, pass, fail);
    end
  endtask

  task automatic drive(logic s, logic v, logic [1:0] r, logic t);
    start = s; resp_valid = v; resp_in = r; tpg_complete = t;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Run 1: three 01 responses, golden 0111, count 3 -> pass
    tbl[0]  = mk(1,0,2'b00,0, 4'b0000,0, 1,0,0,0);
    tbl[1]  = mk(0,1,2'b01,0, 4'b0001,1, 1,0,0,0);
    tbl[2]  = mk(0,1,2'b01,0, 4'b0011,2, 1,0,0,0);
    tbl[3]  = mk(0,1,2'b01,0, 4'b0111,3, 1,0,0,0);
    tbl[4]  = mk(0,0,2'b00,1, 4'b0111,3, 1,0,0,0);
    tbl[5]  = mk(0,0,2'b00,0, 4'b0111,3, 0,1,1,0);
    tbl[6]  = mk(0,1,2'b11,0, 4'b0111,3, 0,1,1,0);
    // Run 2 (start from DONE): middle response 11 corrupts signature -> fail
    tbl[7]  = mk(1,0,2'b00,0, 4'b0000,0, 1,0,0,0);
    tbl[8]  = mk(0,1,2'b01,0, 4'b0001,1, 1,0,0,0);
    tbl[9]  = mk(0,1,2'b11,0, 4'b0001,2, 1,0,0,0);
    tbl[10] = mk(0,1,2'b01,0, 4'b0011,3, 1,0,0,0);
    tbl[11] = mk(0,0,2'b00,1, 4'b0011,3, 1,0,0,0);
    tbl[12] = mk(0,0,2'b00,0, 4'b0011,3, 0,1,0,1);
    // Run 3: golden signature reached with only 2 responses -> fail
    tbl[13] = mk(1,0,2'b00,0, 4'b0000,0, 1,0,0,0);
    tbl[14] = mk(0,1,2'b10,0, 4'b0010,1, 1,0,0,0);
    tbl[15] = mk(0,1,2'b11,0, 4'b0111,2, 1,0,0,0);
    tbl[16] = mk(0,0,2'b00,1, 4'b0111,2, 1,0,0,0);
    tbl[17] = mk(0,0,2'b00,0, 4'b0111,2, 0,1,0,1);
    // Run 4: final response coincides with tpg_complete -> still absorbed, pass
    tbl[18] = mk(1,0,2'b00,0, 4'b0000,0, 1,0,0,0);
    tbl[19] = mk(0,1,2'b01,0, 4'b0001,1, 1,0,0,0);
    tbl[20] = mk(0,1,2'b01,0, 4'b0011,2, 1,0,0,0);
    tbl[21] = mk(0,1,2'b01,1, 4'b0111,3, 1,0,0,0);
    tbl[22] = mk(0,0,2'b00,0, 4'b0111,3, 0,1,1,0);
    // Run 5: walk a 1 into the MSB, then feedback 1000 -> 0011
    tbl[23] = mk(1,0,2'b00,0, 4'b0000,0, 1,0,0,0);
    tbl[24] = mk(0,1,2'b01,0, 4'b0001,1, 1,0,0,0);
    tbl[25] = mk(0,1,2'b00,0, 4'b0010,2, 1,0,0,0);
    tbl[26] = mk(0,1,2'b00,0, 4'b0100,3, 1,0,0,0);
    tbl[27] = mk(0,1,2'b00,0, 4'b1000,4, 1,0,0,0);
    tbl[28] = mk(0,1,2'b00,0, 4'b0011,5, 1,0,0,0);
    // start + tpg_complete + valid together: restart, response dropped, still compacting
    tbl[29] = mk(1,1,2'b01,1, 4'b0000,0, 1,0,0,0);
    tbl[30] = mk(0,1,2'b01,0, 4'b0001,1, 1,0,0,0);
    // start during COMPARE aborts and reseeds
    tbl[31] = mk(0,0,2'b00,1, 4'b0001,1, 1,0,0,0);
    tbl[32] = mk(1,0,2'b00,0, 4'b0000,0, 1,0,0,0);
    tbl[33] = mk(0,1,2'b01,0, 4'b0001,1, 1,0,0,0);

    start = 0; resp_valid = 0; resp_in = 2'b00; tpg_complete = 0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 4'b0000, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Idle ignores responses and tpg_complete
    drive(0, 1, 2'b11, 0);
    check("idle_resp_ignored", 4'b0000, 0, 0, 0, 0, 0);
    drive(0, 0, 2'b00, 1);
    check("idle_tpg_ignored", 4'b0000, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].start, tbl[i].vld, tbl[i].rin, tbl[i].tpg);
      check($sformatf("vec%0d", i), tbl[i].sig, tbl[i].cnt,
            tbl[i].busy, tbl[i].done, tbl[i].pass, tbl[i].fail);
    end

    // Async reset mid-COMPACT takes effect without a clock edge
    start = 0; resp_valid = 0; tpg_complete = 0;
    reset = 1'b0;
    #1;
    check("async_reset_midrun", 4'b0000, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b1;
    drive(0, 1, 2'b01, 0);
    check("after_reset_idle", 4'b0000, 0, 0, 0, 0, 0);

    // Count saturates at all-ones after 17 responses
    drive(1, 0, 2'b00, 0);
    for (int i = 0; i < 17; i++) drive(0, 1, 2'b00, 0);
    check("count_saturate", 4'b0000, 4'd15, 1, 0, 0, 0);
    drive(0, 0, 2'b00, 1);
    drive(0, 0, 2'b00, 0);
    check("saturated_fail", 4'b0000, 4'd15, 0, 1, 0, 1);
    drive(1, 0, 2'b00, 0);
    check("start_in_done", 4'b0000, 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
